// File: rtl/cv32e40p_3voter_fault_mgr_pkg.sv
// Shared types and helpers for the triple-voter fault manager.
package cv32e40p_ft_pkg;

  typedef enum logic [1:0] {
    FM_NORMAL   = 2'b00,
    FM_DEGRADED = 2'b01,
    FM_FAILED   = 2'b10
  } fm_state_e;

  localparam logic [1:0] REPL_1 = 2'd1;
  localparam logic [1:0] REPL_2 = 2'd2;
  localparam logic [1:0] REPL_3 = 2'd3;

  // Number of set bits in a 3-bit replica vector.
  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // Replica index of a one-hot replica vector; 0 when no bit is set.
  function automatic logic [1:0] onehot_to_id(input logic [2:0] v);
    logic [1:0] id;
    id = 2'd0;
    if (v[0]) id = REPL_1;
    if (v[1]) id = REPL_2;
    if (v[2]) id = REPL_3;
    return id;
  endfunction

endpackage

// File: rtl/cv32e40p_3voter_fault_mgr_if.sv
// Voter-side signal bundle of the fault manager.
interface cv32e40p_3voter_fault_mgr_if #(
  parameter int unsigned THRESH = 8
);
  localparam int unsigned CW = $clog2(THRESH + 1);

  logic            valid_i;
  logic            err_detected_1_i;
  logic            err_detected_2_i;
  logic            err_detected_3_i;
  logic            err_corrected_i;
  logic            clear_i;
  logic            resync_ack_i;
  logic [2:0]      broken_block_o;
  logic [1:0]      state_o;
  logic            degraded_o;
  logic            fatal_o;
  logic            resync_req_o;
  logic [1:0]      resync_id_o;
  logic [3*CW-1:0] err_cnt_o;

  modport master (
    output valid_i, err_detected_1_i, err_detected_2_i, err_detected_3_i,
           err_corrected_i, clear_i, resync_ack_i,
    input  broken_block_o, state_o, degraded_o, fatal_o,
           resync_req_o, resync_id_o, err_cnt_o
  );

  modport slave (
    input  valid_i, err_detected_1_i, err_detected_2_i, err_detected_3_i,
           err_corrected_i, clear_i, resync_ack_i,
    output broken_block_o, state_o, degraded_o, fatal_o,
           resync_req_o, resync_id_o, err_cnt_o
  );
endinterface

// File: rtl/cv32e40p_3voter_fault_mgr_leaky_cnt.sv
// Saturating per-replica error counter with leak, freeze and clear.
module cv32e40p_leaky_cnt #(
  parameter  int unsigned THRESH = 8,
  localparam int unsigned CW     = $clog2(THRESH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          dec_i,
  input  logic          freeze_i,
  input  logic          clear_i,
  output logic [CW-1:0] cnt_o,
  output logic [CW-1:0] cnt_next_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, freeze holds, inc and dec together cancel.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (!freeze_i) begin
      if (inc_i && !dec_i && cnt_q != CW'(THRESH)) cnt_d = cnt_q + CW'(1);
      else if (dec_i && !inc_i && cnt_q != '0)     cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;
endmodule

// File: rtl/cv32e40p_3voter_fault_mgr.sv
// Fault manager for the triple-redundant voter: error counting with leak,
// broken-replica selection, resync requests and fatal detection.
module cv32e40p_3voter_fault_mgr
  import cv32e40p_ft_pkg::*;
#(
  parameter int unsigned THRESH = 8,
  parameter int unsigned WINDOW = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  cv32e40p_3voter_fault_mgr_if.slave  bus
);
  localparam int unsigned CW = $clog2(THRESH + 1);
  localparam int unsigned WW = $clog2(WINDOW);

  fm_state_e     state_q, state_d;
  logic [2:0]    broken_q, broken_d;
  logic          req_q, req_d;
  logic [1:0]    id_q, id_d;
  logic [WW-1:0] wcnt_q, wcnt_d;

  logic [CW-1:0] cnt_q  [3];
  logic [CW-1:0] cnt_nx [3];
  logic [2:0]    err_v, reach;
  logic          in_normal, leak, issue;

  assign err_v     = {bus.err_detected_3_i, bus.err_detected_2_i, bus.err_detected_1_i}
                     & {3{bus.valid_i}};
  assign in_normal = (state_q == FM_NORMAL);
  assign leak      = (wcnt_q == WW'(WINDOW - 1));

  for (genvar k = 0; k < 3; k++) begin : g_cnt
    cv32e40p_leaky_cnt #(.THRESH(THRESH)) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (err_v[k] & in_normal),
      .dec_i      (leak),
      .freeze_i   (!in_normal),
      .clear_i    (bus.clear_i),
      .cnt_o      (cnt_q[k]),
      .cnt_next_o (cnt_nx[k])
    );
    assign reach[k] = in_normal && (cnt_nx[k] == CW'(THRESH));
  end

  // Resync fires only for a lone corrected error on a replica still below threshold.
  assign issue = in_normal && bus.valid_i && bus.err_corrected_i &&
                 (popcnt3(err_v) == 2'd1) && !(|(reach & err_v)) && !req_q;

  // Next-state logic for the FSM, window counter and resync handshake.
  always_comb begin
    state_d  = state_q;
    broken_d = broken_q;
    req_d    = req_q;
    id_d     = id_q;
    wcnt_d   = leak ? '0 : wcnt_q + WW'(1);

    if (req_q && bus.resync_ack_i) req_d = 1'b0;
    else if (issue) begin
      req_d = 1'b1;
      id_d  = onehot_to_id(err_v);
    end

    unique case (state_q)
      FM_NORMAL: begin
        if (err_v == 3'b111) state_d = FM_FAILED;
        else if (popcnt3(reach) == 2'd1) begin
          state_d  = FM_DEGRADED;
          broken_d = reach;
        end else if (popcnt3(reach) >= 2'd2) state_d = FM_FAILED;
      end
      FM_DEGRADED: if (|(err_v & ~broken_q)) state_d = FM_FAILED;
      FM_FAILED:   state_d = FM_FAILED;
      default:     state_d = FM_FAILED;
    endcase

    if (bus.clear_i) begin
      state_d  = FM_NORMAL;
      broken_d = '0;
      req_d    = 1'b0;
      id_d     = '0;
      wcnt_d   = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= FM_NORMAL;
      broken_q <= '0;
      req_q    <= 1'b0;
      id_q     <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      broken_q <= broken_d;
      req_q    <= req_d;
      id_q     <= id_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign bus.broken_block_o = broken_q;
  assign bus.state_o        = state_q;
  assign bus.degraded_o     = (state_q == FM_DEGRADED);
  assign bus.fatal_o        = (state_q == FM_FAILED);
  assign bus.resync_req_o   = req_q;
  assign bus.resync_id_o    = id_q;
  assign bus.err_cnt_o      = {cnt_q[2], cnt_q[1], cnt_q[0]};
endmodule
